lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Pipeline-side load/store initiator that drives the data-memory responder over a valid/ready request bus plus a response channel.
- Captures a load/store from the memory stage and generates the word address, byte-lane mask and lane-replicated store data.
- For loads, waits for the response, then extracts and sign- or zero-extends the addressed byte or halfword.
- Stalls the pipeline while a transaction is outstanding and flags illegal accesses and timeouts.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_rsp_valid on a load before an error completion.
- CNT_W, 8: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- lsu_req  in  1  memory-stage request; held high until lsu_done.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_func3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store source (rs2).
- lsu_stall  out  1  freeze pipeline.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_rdata  out  32  extended load result, valid with lsu_done.
- lsu_err  out  1  illegal/misaligned/timeout, valid with lsu_done.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  responder accepts request.
- bus_we  out  1  write request.
- bus_addr  out  32  word address, {lsu_addr[31:2],2'b00}.
- bus_mask  out  4  byte-lane enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rsp_valid  in  1  load data valid.
- bus_rsp_data  in  32  raw word from responder.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; bus_req_valid, lsu_done, lsu_err, lsu_stall = 0; lsu_rdata, bus_addr, bus_mask, bus_wdata = 0; timeout counter = 0.
- FSM states: IDLE, REQ, RSP, DONE.
  - IDLE and lsu_req=1 with a legal op: register we, func3, addr[1:0], bus fields; go to REQ.
  - IDLE and lsu_req=1 with an illegal op: go to DONE with err=1 and no bus activity.
  - REQ: bus_req_valid=1 with fields stable until handshake.
  - REQ and bus_req_ready=1: a store (posted) goes to DONE; a load goes to RSP with counter cleared.
  - RSP: counter increments each cycle.
  - RSP and bus_rsp_valid=1: latch the extracted data; go to DONE.
  - RSP and counter==TIMEOUT with no rsp: go to DONE with err=1 and rdata=0.
  - DONE: lsu_done=1 for exactly one cycle; return to IDLE.
- lsu_stall = (IDLE & lsu_req) | REQ | RSP. It is 0 in DONE.
- Minimum latency:
  - Store: request cycle, handshake cycle, then done 2 cycles after lsu_req when ready is already high.
  - Load: adds the response wait; done 1 cycle after bus_rsp_valid.
- Masks:
  - B: 4'b0001 << addr[1:0], wdata = {4{byte}}.
  - H: 4'b0011 << {addr[1],1'b0}, wdata = {2{half}}.
  - W: 4'b1111.
  - Loads drive the same mask with wdata=0.
- Load extract:
  - B/BU select the lane by addr[1:0]; H/HU select by addr[1].
  - 000/001 sign-extend; 100/101 zero-extend; 010 passes through.
- Illegal op: store func3 not in {000,001,010}, or load func3 in {011,110,111}.
- Boundary conditions:
  - bus_rsp_valid outside RSP is ignored.
  - A new lsu_req is sampled only in IDLE.
  - bus_rsp_valid in the same cycle the counter reaches TIMEOUT: the response wins, err=0.
  - Reset during REQ or RSP drops bus_req_valid immediately; a pending response is discarded.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - H/HU/SH with addr[0]=1 are misaligned.
  - W/SW with addr[1:0]!=0 are misaligned.
  - A misaligned access goes IDLE->DONE with err=1, no bus transaction, rdata=0.
- Undefined:
  - The low address bits are ignored: halfword uses addr[1] only, word uses aligned access.
  - A misaligned access is never an error.

Decomposition:
- Package lsu_pkg contains:
  - enum of funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state enum;
  - mask constants MASK_B, MASK_H, MASK_W.
- Sub-module lsu_lane_align: combinational store mask/replication and load lane extract/extension, instantiated once.

Test Plan:
- SB addr 0x0000_0013, wdata 0x0000_00A5, ready high → bus_addr 0x10, mask 1000, wdata 0xA5A5A5A5, we=1; done 2 cycles after req, err=0.
- LB addr 0x12, rsp_data 0x1280_3456 after 3 cycles → rdata 0xFFFF_FF80. The same access as LBU → 0x0000_0080.
- LHU addr 0x22, rsp 0xBEEF_0000 → rdata 0x0000_BEEF, mask 1100. Hold bus_req_ready low 4 cycles → fields stable, stall high throughout.
- LW with no response, TIMEOUT=255 → done with err=1, rdata 0 exactly 256 cycles after the handshake.
- Misaligned and illegal ops:
  - LW addr 0x01 with LSU_MISALIGN_TRAP_EN → no bus_req_valid, err=1.
  - The same LW without the macro → bus_addr 0x00, mask 1111, err=0.
  - Store func3=100 → err=1, no bus activity.
- Assert rst low during RSP → bus_req_valid 0 and state IDLE immediately. A later bus_rsp_valid produces no lsu_done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU bus master: funct3 codes, FSM states,
// byte-lane mask constants and the op-legality checks.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_f3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE
    } lsu_state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Stores only exist as B/H/W; loads also allow the unsigned B/H forms.
    function automatic logic op_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store mask and data replication, plus
// load lane extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  mask,
    output logic [31:0] st_rep,
    output logic [31:0] ld_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_raw[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        mask    = MASK_W;
        st_rep  = st_data;
        ld_ext  = ld_raw;
        case (func3)
            F3_B: begin
                mask   = MASK_B << addr_lo;
                st_rep = {4{st_data[7:0]}};
                ld_ext = {{24{ld_byte[7]}}, ld_byte};
            end
            F3_BU: begin
                mask   = MASK_B << addr_lo;
                st_rep = {4{st_data[7:0]}};
                ld_ext = {24'h0, ld_byte};
            end
            // Halfword lanes ignore addr[0]; misalignment is handled upstream.
            F3_H: begin
                mask   = MASK_H << {addr_lo[1], 1'b0};
                st_rep = {2{st_data[15:0]}};
                ld_ext = {{16{ld_half[15]}}, ld_half};
            end
            F3_HU: begin
                mask   = MASK_H << {addr_lo[1], 1'b0};
                st_rep = {2{st_data[15:0]}};
                ld_ext = {16'h0, ld_half};
            end
            default: begin
                mask   = MASK_W;
                st_rep = st_data;
                ld_ext = ld_raw;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: IDLE -> REQ -> (RSP) -> DONE handshake FSM.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned H/W accesses into errors.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_func3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_mask,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    lsu_state_e       state_q, state_d;
    logic             req_valid_q, req_valid_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       mask_q, mask_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_mask;
    logic [31:0] al_st;
    logic [31:0] al_ld;
    logic        bad_op;

    // One aligner serves both directions: live inputs while idle, the
    // captured op afterwards for the load extract.
    assign al_f3 = (state_q == ST_IDLE) ? lsu_func3     : f3_q;
    assign al_lo = (state_q == ST_IDLE) ? lsu_addr[1:0] : lo_q;

    lsu_lane_align u_align (
        .func3   (al_f3),
        .addr_lo (al_lo),
        .st_data (lsu_wdata),
        .ld_raw  (bus_rsp_data),
        .mask    (al_mask),
        .st_rep  (al_st),
        .ld_ext  (al_ld)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_op = op_illegal(lsu_we, lsu_func3) | op_misaligned(lsu_func3, lsu_addr[1:0]);
`else
    assign bad_op = op_illegal(lsu_we, lsu_func3);
`endif

    always_comb begin
        state_d     = state_q;
        req_valid_d = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req) begin
                    if (bad_op) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        we_d        = lsu_we;
                        f3_d        = lsu_func3;
                        lo_d        = lsu_addr[1:0];
                        addr_d      = {lsu_addr[31:2], 2'b00};
                        mask_d      = al_mask;
                        wdata_d     = lsu_we ? al_st : 32'h0;
                    end
                end
            end
            ST_REQ: begin
                req_valid_d = 1'b1;
                if (bus_req_ready) begin
                    req_valid_d = 1'b0;
                    if (we_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = ST_RSP;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RSP: begin
                // A response on the final counted cycle still wins over timeout.
                if (bus_rsp_valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rdata_d = al_ld;
                end else if (cnt_q == TO_CNT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            mask_q      <= 4'h0;
            wdata_q     <= 32'h0;
            f3_q        <= 3'h0;
            lo_q        <= 2'h0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign lsu_stall     = ((state_q == ST_IDLE) && lsu_req) || (state_q == ST_REQ) ||
                           (state_q == ST_RSP);
    assign lsu_done      = done_q;
    assign lsu_err       = err_q;
    assign lsu_rdata     = rdata_q;
    assign bus_req_valid = req_valid_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_mask      = mask_q;
    assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed scenarios plus randomized
// ops compared against a byte-arithmetic reference model.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we;
    logic [2:0]  lsu_func3;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_func3(lsu_func3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_mask(bus_mask), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
        int nb = nbytes(f3);
        if (nb == 1) return int'(a % 4);
        if (nb == 2) return int'((a % 4) / 2 * 2);
        return 0;
    endfunction

    function automatic logic m_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        if (we) bad = (f3 > 3'd2);
        else    bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (nbytes(f3) == 2 && (a % 2) != 0) bad = 1'b1;
        if (nbytes(f3) == 4 && (a % 4) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
        int v = ((1 << nbytes(f3)) - 1) << lane_base(f3, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = 32'h0;
        if (we)
            for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] raw);
        int    nb = nbytes(f3);
        longint v;
        v = (longint'(raw) >> (8 * lane_base(f3, a))) & ((64'sd1 << (8 * nb)) - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
        return v[31:0];
    endfunction

    // ---------------- transaction driver (records observations) ----------------
    int          o_done_cyc, o_h;
    logic        o_err, o_saw_valid, o_unstable, o_stall_bad, o_done_next, o_stall_after, o_we;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_mask;

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int rdly, input int rspdly,
                          input logic [31:0] rdat);
        int   cyc = 0, nval = 0;
        logic hs_pend;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_func3 = f3; lsu_addr = a; lsu_wdata = wd;
        bus_req_ready = (rdly == 0); bus_rsp_valid = 1'b0; bus_rsp_data = rdat;
        o_done_cyc = -1; o_h = -1; o_err = 1'bx; o_rdata = 'x; o_saw_valid = 1'b0;
        o_unstable = 1'b0; o_addr = 'x; o_mask = 'x; o_wdata = 'x; o_we = 1'bx;
        #1 o_stall_bad = (lsu_stall !== 1'b1);
        while (o_done_cyc < 0 && cyc < 400) begin
            hs_pend = (bus_req_valid === 1'b1) && bus_req_ready;
            @(posedge clk); #1; cyc++;
            if (hs_pend) o_h = cyc;
            if (lsu_done === 1'b1) begin
                o_done_cyc = cyc; o_err = lsu_err; o_rdata = lsu_rdata;
                if (lsu_stall !== 1'b0) o_stall_bad = 1'b1;
            end else begin
                if (lsu_stall !== 1'b1) o_stall_bad = 1'b1;
                if (bus_req_valid === 1'b1) begin
                    nval++;
                    if (!o_saw_valid) begin
                        o_saw_valid = 1'b1; o_addr = bus_addr; o_mask = bus_mask;
                        o_wdata = bus_wdata; o_we = bus_we;
                    end else if (bus_addr !== o_addr || bus_mask !== o_mask ||
                                 bus_wdata !== o_wdata || bus_we !== o_we) o_unstable = 1'b1;
                end
                bus_req_ready = (nval > rdly);
                bus_rsp_valid = (o_h >= 0 && rspdly > 0 && cyc - o_h == rspdly - 1);
            end
        end
        lsu_req = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(posedge clk); #1;
        o_done_next = lsu_done; o_stall_after = lsu_stall;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b0; lsu_req = 0; lsu_we = 0; lsu_func3 = 0; lsu_addr = 0; lsu_wdata = 0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus_req_valid, lsu_done, lsu_err, lsu_stall} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {bus_req_valid, lsu_done, lsu_err, lsu_stall}); end
        checks++; if ({lsu_rdata, bus_addr, bus_mask, bus_wdata} !== 100'h0) begin
            errors++; $display("FAIL reset_data rdata %h addr %h mask %b wdata %h exp 0",
                               lsu_rdata, bus_addr, bus_mask, bus_wdata); end
        @(negedge clk); rst = 1'b1;
        // a stray response while idle must not complete anything
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (lsu_done !== 1'b0 || bus_req_valid !== 1'b0) begin
                errors++; $display("FAIL idle_rsp_ignored done %b valid %b exp 0 0", lsu_done, bus_req_valid); end
        end
        @(negedge clk); bus_rsp_valid = 1'b0;
    endtask

    task automatic test_sb;
        run_op(1'b1, 3'b000, 32'h13, 32'hA5, 0, 0, 32'h0);
        checks++; if (o_addr !== 32'h10 || o_mask !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 || o_we !== 1'b1) begin
            errors++; $display("FAIL sb_fields addr %h mask %b wdata %h we %b exp 10 1000 a5a5a5a5 1",
                               o_addr, o_mask, o_wdata, o_we); end
        checks++; if (o_done_cyc !== 2 || o_err !== 1'b0) begin
            errors++; $display("FAIL sb_done cyc %0d err %b exp 2 0", o_done_cyc, o_err); end
        checks++; if (o_done_next !== 1'b0 || o_stall_bad !== 1'b0) begin
            errors++; $display("FAIL sb_pulse done_next %b stall_bad %b exp 0 0", o_done_next, o_stall_bad); end
    endtask

    task automatic test_lb_lbu;
        run_op(1'b0, 3'b000, 32'h12, 32'h0, 0, 3, 32'h1280_3456);
        checks++; if (o_rdata !== 32'hFFFF_FF80 || o_err !== 1'b0 || o_done_cyc !== 5) begin
            errors++; $display("FAIL lb rdata %h err %b cyc %0d exp ffffff80 0 5", o_rdata, o_err, o_done_cyc); end
        checks++; if (o_mask !== 4'b0100 || o_wdata !== 32'h0 || o_we !== 1'b0) begin
            errors++; $display("FAIL lb_fields mask %b wdata %h we %b exp 0100 0 0", o_mask, o_wdata, o_we); end
        run_op(1'b0, 3'b100, 32'h12, 32'h0, 0, 3, 32'h1280_3456);
        checks++; if (o_rdata !== 32'h0000_0080 || o_err !== 1'b0) begin
            errors++; $display("FAIL lbu rdata %h err %b exp 00000080 0", o_rdata, o_err); end
    endtask

    task automatic test_lhu_stall;
        run_op(1'b0, 3'b101, 32'h22, 32'h0, 4, 2, 32'hBEEF_0000);
        checks++; if (o_rdata !== 32'h0000_BEEF || o_mask !== 4'b1100 || o_addr !== 32'h20) begin
            errors++; $display("FAIL lhu rdata %h mask %b addr %h exp 0000beef 1100 20", o_rdata, o_mask, o_addr); end
        checks++; if (o_unstable !== 1'b0 || o_stall_bad !== 1'b0 || o_done_cyc !== 8) begin
            errors++; $display("FAIL lhu_hold unstable %b stall_bad %b cyc %0d exp 0 0 8",
                               o_unstable, o_stall_bad, o_done_cyc); end
    endtask

    task automatic test_timeout;
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h1234_5678);
        checks++; if (o_done_cyc !== o_h + 256 || o_h !== 2) begin
            errors++; $display("FAIL timeout_lat done %0d hs %0d exp 258 2", o_done_cyc, o_h); end
        checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout_err err %b rdata %h exp 1 0", o_err, o_rdata); end
        // a response landing on the last counted cycle beats the timeout
        run_op(1'b0, 3'b010, 32'h104, 32'h0, 0, 256, 32'hCAFE_F00D);
        checks++; if (o_err !== 1'b0 || o_rdata !== 32'hCAFE_F00D || o_done_cyc !== 258) begin
            errors++; $display("FAIL rsp_at_timeout err %b rdata %h cyc %0d exp 0 cafef00d 258",
                               o_err, o_rdata, o_done_cyc); end
    endtask

    task automatic test_misalign_illegal;
        run_op(1'b0, 3'b010, 32'h01, 32'h0, 0, 1, 32'h8765_4321);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (o_saw_valid !== 1'b0 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_done_cyc !== 1) begin
            errors++; $display("FAIL lw_misalign valid %b err %b rdata %h cyc %0d exp 0 1 0 1",
                               o_saw_valid, o_err, o_rdata, o_done_cyc); end
`else
        checks++; if (o_addr !== 32'h0 || o_mask !== 4'b1111 || o_err !== 1'b0 || o_rdata !== 32'h8765_4321) begin
            errors++; $display("FAIL lw_misalign addr %h mask %b err %b rdata %h exp 0 1111 0 87654321",
                               o_addr, o_mask, o_err, o_rdata); end
`endif
        run_op(1'b1, 3'b100, 32'h40, 32'h55, 0, 0, 32'h0);
        checks++; if (o_saw_valid !== 1'b0 || o_err !== 1'b1 || o_done_cyc !== 1 || o_done_next !== 1'b0) begin
            errors++; $display("FAIL st_illegal valid %b err %b cyc %0d done_next %b exp 0 1 1 0",
                               o_saw_valid, o_err, o_done_cyc, o_done_next); end
    endtask

    task automatic test_reset_midflight;
        // reset while stuck in REQ
        @(negedge clk);
        lsu_req = 1; lsu_we = 0; lsu_func3 = 3'b010; lsu_addr = 32'h80; bus_req_ready = 0;
        @(posedge clk); #1;
        @(negedge clk); #2 rst = 1'b0; lsu_req = 0; #1;
        checks++; if (bus_req_valid !== 1'b0 || lsu_stall !== 1'b0 || bus_addr !== 32'h0) begin
            errors++; $display("FAIL rst_in_req valid %b stall %b addr %h exp 0 0 0", bus_req_valid, lsu_stall, bus_addr); end
        @(negedge clk); rst = 1'b1;
        // reset while waiting in RSP
        @(negedge clk);
        lsu_req = 1; lsu_we = 0; lsu_func3 = 3'b010; lsu_addr = 32'h84; bus_req_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_req_ready = 0;
        #2 rst = 1'b0; lsu_req = 0; #1;
        checks++; if (bus_req_valid !== 1'b0 || lsu_stall !== 1'b0 || lsu_done !== 1'b0) begin
            errors++; $display("FAIL rst_in_rsp valid %b stall %b done %b exp 0 0 0", bus_req_valid, lsu_stall, lsu_done); end
        @(negedge clk); rst = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (lsu_done !== 1'b0) begin
                errors++; $display("FAIL rsp_after_rst done %b exp 0", lsu_done); end
        end
        @(negedge clk); bus_rsp_valid = 1'b0;
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic        we  = 1'($urandom_range(0, 1));
            logic [2:0]  f3  = 3'($urandom_range(0, 7));
            logic [31:0] a   = $urandom;
            logic [31:0] wd  = $urandom;
            logic [31:0] raw = $urandom;
            int          rd  = int'($urandom_range(0, 3));
            int          rs  = int'($urandom_range(1, 4));
            int          exp_cyc;
            run_op(we, f3, a, wd, rd, rs, raw);
            if (m_illegal(we, f3, a)) begin
                checks++; if (o_err !== 1'b1 || o_saw_valid !== 1'b0 || o_done_cyc !== 1) begin
                    errors++; $display("FAIL rnd_illegal we %b f3 %0d a %h err %b valid %b cyc %0d exp 1 0 1",
                                       we, f3, a, o_err, o_saw_valid, o_done_cyc); end
            end else begin
                exp_cyc = we ? 2 + rd : 2 + rd + rs;
                checks++; if (o_err !== 1'b0 || o_done_cyc !== exp_cyc || o_done_next !== 1'b0) begin
                    errors++; $display("FAIL rnd_done we %b f3 %0d err %b cyc %0d exp 0 %0d",
                                       we, f3, o_err, o_done_cyc, exp_cyc); end
                checks++; if (o_addr !== {a[31:2], 2'b00} || o_mask !== m_mask(f3, a) ||
                              o_wdata !== m_wdata(we, f3, wd) || o_we !== we || o_unstable !== 1'b0) begin
                    errors++; $display("FAIL rnd_bus f3 %0d a %h addr %h mask %b wdata %h exp mask %b wdata %h",
                                       f3, a, o_addr, o_mask, o_wdata, m_mask(f3, a), m_wdata(we, f3, wd)); end
                if (!we) begin
                    checks++; if (o_rdata !== m_rdata(f3, a, raw)) begin
                        errors++; $display("FAIL rnd_rdata f3 %0d a %h raw %h got %h exp %h",
                                           f3, a, raw, o_rdata, m_rdata(f3, a, raw)); end
                end
            end
            checks++; if (o_stall_bad !== 1'b0 || o_stall_after !== 1'b0) begin
                errors++; $display("FAIL rnd_stall bad %b after %b exp 0 0", o_stall_bad, o_stall_after); end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_lb_lbu();
        test_lhu_stall();
        test_timeout();
        test_misalign_illegal();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
